// File: rtl/inst_loader.sv
// Writable instruction RAM with a valid/ready load engine.
// The fetch side reads combinationally, exactly like the instruction ROM.
module inst_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A:0]   Length,
    input  logic         InValid,
    input  logic [W-1:0] InData,
    output logic         InReady,
    input  logic [A-1:0] InstAddress,
    output logic [W-1:0] InstOut,
    output logic         Loading,
    output logic         Done,
    output logic         Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [A:0] DEPTH = {1'b1, {A{1'b0}}};
    localparam logic [A:0] ONE   = {{A{1'b0}}, 1'b1};

    state_t         state;
    state_t         state_n;
    logic [A-1:0]   wr_ptr;
    logic [A:0]     remaining;
    logic           done_q;
    logic           err_q;
    logic [W-1:0]   mem [2**A];

    logic start_req;
    logic start_ok;
    logic start_bad;
    logic xfer;
    logic last_xfer;

    assign start_req = (state != LOAD) && Start;
    assign start_ok  = start_req && (Length <= DEPTH);
    assign start_bad = start_req && (Length > DEPTH);
    assign xfer      = InValid && InReady;
    assign last_xfer = xfer && (remaining == ONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_n = (Length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (last_xfer) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        InReady = (state == LOAD);
        Loading = (state == LOAD);
        Done    = done_q;
        Err     = err_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr    <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                wr_ptr    <= '0;
                remaining <= Length;
                done_q    <= (Length == '0);
            end else if (xfer) begin
                // Full-depth loads wrap wr_ptr back to 0 on the final word
                wr_ptr    <= wr_ptr + A'(1);
                remaining <= remaining - ONE;
                if (remaining == ONE) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Array is never cleared; a reset mid-load leaves a partial program
    always_ff @(posedge Clk) begin
        if (xfer && !Reset) begin
            mem[wr_ptr] <= InData;
        end
    end

    assign InstOut = mem[InstAddress];

endmodule

// File: tb/tb_inst_loader.sv
// Randomised self-checking bench for inst_loader.
// A flat array model tracks which addresses hold which words.
module tb_inst_loader;

    localparam int A = 10;
    localparam int W = 9;
    localparam int DEPTH = 1 << A;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [A:0]   Length;
    logic         InValid;
    logic [W-1:0] InData;
    logic         InReady;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstOut;
    logic         Loading;
    logic         Done;
    logic         Err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] ref_mem [DEPTH];
    bit           ref_known [DEPTH];
    logic [W-1:0] stim [DEPTH];

    inst_loader #(.A(A), .W(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Length(Length),
        .InValid(InValid),
        .InData(InData),
        .InReady(InReady),
        .InstAddress(InstAddress),
        .InstOut(InstOut),
        .Loading(Loading),
        .Done(Done),
        .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        InValid = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic issue_start(input int len);
        Start = 1'b1;
        Length = (A+1)'(len);
        tick();
        Start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: alternate, 2: back-to-back with Start held
    // mode 3: random valid
    task automatic stream(input int n, input int mode,
                          output int lcnt, output bit to);
        int sent;
        int cyc;
        bit v;
        bit acc;
        sent = 0;
        cyc = 0;
        lcnt = 0;
        to = 1'b0;
        while (sent < n) begin
            if (cyc > 4 * n + 20) begin
                to = 1'b1;
                break;
            end
            case (mode)
                1: v = (cyc % 2 == 0);
                3: v = 1'($urandom_range(0, 1));
                default: v = 1'b1;
            endcase
            if (mode == 2) begin
                Start = 1'b1;
                Length = (A+1)'($urandom_range(1, 7));
            end
            if (Loading) lcnt++;
            InValid = v;
            InData = v ? stim[sent] : W'($urandom);
            acc = v && InReady;
            tick();
            if (acc) begin
                ref_mem[sent % DEPTH] = stim[sent];
                ref_known[sent % DEPTH] = 1'b1;
                sent++;
            end
            cyc++;
        end
        Start = 1'b0;
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        Length = (A+1)'(3);
        InValid = 1'b0;
        InData = '0;
        InstAddress = '0;
        tick();
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        checks++;
        if (InReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_inready got=%b want=0", InReady);
        end
        checks++;
        if (Loading !== 1'b0) begin
            errors++;
            $display("FAIL reset_loading got=%b want=0", Loading);
        end
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b want=0", Done);
        end
        checks++;
        if (Err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got=%b want=0", Err);
        end
        tick();
        checks++;
        if (Loading !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold got=%b want=0", Loading);
        end
    endtask

    task automatic test_back_to_back();
        int lcnt;
        bit to;
        stim[0] = 9'h1A5;
        stim[1] = 9'h003;
        stim[2] = 9'h1FF;
        issue_start(3);
        checks++;
        if (Loading !== 1'b1 || InReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_enter got=%b%b want=11", Loading, InReady);
        end
        stream(3, 0, lcnt, to);
        checks++;
        if (to || lcnt != 3) begin
            errors++;
            $display("FAIL b2b_loading_cycles got=%0d want=3 timeout=%0d",
                     lcnt, to);
        end
        checks++;
        if (Done !== 1'b1 || InReady !== 1'b0 || Loading !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got=%b%b%b want=100",
                     Done, InReady, Loading);
        end
        for (int i = 0; i < 3; i++) begin
            InstAddress = A'(i);
            #1;
            checks++;
            if (InstOut !== ref_mem[i]) begin
                errors++;
                $display("FAIL b2b_read addr=%0d got=%h want=%h",
                         i, InstOut, ref_mem[i]);
            end
        end
    endtask

    task automatic test_gaps();
        int lcnt;
        bit to;
        for (int i = 0; i < 4; i++) stim[i] = W'($urandom);
        issue_start(4);
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done_cleared got=%b want=0", Done);
        end
        stream(3, 1, lcnt, to);
        tick();
        checks++;
        if (Done !== 1'b0 || Loading !== 1'b1) begin
            errors++;
            $display("FAIL gaps_early_done got=%b%b want=01", Done, Loading);
        end
        for (int i = 0; i < 4; i++) stim[i] = ref_mem[i];
        InValid = 1'b1;
        InData = stim[3] ^ 9'h0F0;
        stim[3] = InData;
        tick();
        InValid = 1'b0;
        ref_mem[3] = stim[3];
        checks++;
        if (to || Done !== 1'b1 || Loading !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done got=%b%b want=10 timeout=%0d",
                     Done, Loading, to);
        end
        for (int i = 0; i < 4; i++) begin
            InstAddress = A'(i);
            #1;
            checks++;
            if (InstOut !== ref_mem[i]) begin
                errors++;
                $display("FAIL gaps_read addr=%0d got=%h want=%h",
                         i, InstOut, ref_mem[i]);
            end
        end
    endtask

    task automatic test_random();
        int lcnt;
        bit to;
        int n;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) stim[i] = W'($urandom);
            issue_start(n);
            stream(n, 3, lcnt, to);
            checks++;
            if (to || Done !== 1'b1 || InReady !== 1'b0) begin
                errors++;
                $display("FAIL rand_done len=%0d got=%b%b want=10 to=%0d",
                         n, Done, InReady, to);
            end
            for (int i = 0; i < n; i++) begin
                InstAddress = A'(i);
                #1;
                checks++;
                if (InstOut !== ref_mem[i]) begin
                    errors++;
                    $display("FAIL rand_read len=%0d addr=%0d got=%h want=%h",
                             n, i, InstOut, ref_mem[i]);
                end
            end
        end
    endtask

    task automatic test_len_bounds();
        int bad;
        do_reset();
        InValid = 1'b1;
        InData = 9'h0AA;
        issue_start(0);
        InValid = 1'b0;
        checks++;
        if (Done !== 1'b1 || Loading !== 1'b0 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL zero_len got=%b%b%b want=100",
                     Done, Loading, InReady);
        end
        InstAddress = '0;
        #1;
        checks++;
        if (InstOut !== ref_mem[0]) begin
            errors++;
            $display("FAIL zero_len_mem got=%h want=%h", InstOut, ref_mem[0]);
        end
        do_reset();
        for (int r = 0; r < 3; r++) begin
            bad = (r == 0) ? DEPTH + 1 : $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
            issue_start(bad);
            checks++;
            if (Err !== 1'b1 || Loading !== 1'b0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL bad_len=%0d got=%b%b%b want=100",
                         bad, Err, Loading, Done);
            end
            tick();
            checks++;
            if (Err !== 1'b0 || Loading !== 1'b0 || Done !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_pulse=%0d got=%b%b%b want=000",
                         bad, Err, Loading, Done);
            end
        end
    endtask

    task automatic test_full_load();
        int lcnt;
        bit to;
        for (int i = 0; i < DEPTH; i++) stim[i] = W'(i) ^ 9'h155;
        issue_start(DEPTH);
        stream(DEPTH, 2, lcnt, to);
        checks++;
        if (to || lcnt != DEPTH) begin
            errors++;
            $display("FAIL full_loading_cycles got=%0d want=%0d to=%0d",
                     lcnt, DEPTH, to);
        end
        checks++;
        if (Done !== 1'b1 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL full_done got=%b%b want=10", Done, InReady);
        end
        InValid = 1'b1;
        InData = 9'h000;
        tick();
        InValid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            InstAddress = A'(i);
            #1;
            checks++;
            if (InstOut !== ref_mem[i]) begin
                errors++;
                $display("FAIL full_read addr=%0d got=%h want=%h",
                         i, InstOut, ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int lcnt;
        bit to;
        for (int i = 0; i < 5; i++) stim[i] = W'($urandom);
        issue_start(5);
        stream(2, 0, lcnt, to);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (to || Loading !== 1'b0 || Done !== 1'b0 || InReady !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got=%b%b%b want=000 to=%0d",
                     Loading, Done, InReady, to);
        end
        for (int i = 0; i < 5; i++) begin
            InstAddress = A'(i);
            #1;
            checks++;
            if (InstOut !== ref_mem[i]) begin
                errors++;
                $display("FAIL mid_reset_read addr=%0d got=%h want=%h",
                         i, InstOut, ref_mem[i]);
            end
        end
        for (int i = 0; i < 2; i++) stim[i] = W'($urandom);
        issue_start(2);
        stream(2, 0, lcnt, to);
        checks++;
        if (to || Done !== 1'b1) begin
            errors++;
            $display("FAIL reload_done got=%b want=1 to=%0d", Done, to);
        end
        for (int i = 0; i < 5; i++) begin
            InstAddress = A'(i);
            #1;
            checks++;
            if (InstOut !== ref_mem[i]) begin
                errors++;
                $display("FAIL reload_read addr=%0d got=%h want=%h",
                         i, InstOut, ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_random();
        test_len_bounds();
        test_full_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
